// File: rtl/dip_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dip_game_pkg
// Description : Shared encodings for the game-side display path.
// Revision    : 1.0 - initial release
// ============================================================================
package dip_game_pkg;

    localparam int DISP_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_TRIGGER   = 2'd1,
        ARB_WAIT_DONE = 2'd2,
        ARB_RELEASE   = 2'd3
    } arb_state_t;

endpackage : dip_game_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker; first set request at or
//               after rr_ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int w_idx;
        w_idx  = 0;
        winner = '0;
        valid  = 1'b0;
        // Walk from the farthest offset back to rr_ptr so the closest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(rr_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                winner = IDX_W'(w_idx);
                valid  = 1'b1;
            end
        end
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : display_arbiter
// Description : Round-robin arbiter sharing one seven-segment display
//               controller between NUM_REQ requesters, with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module display_arbiter
    import dip_game_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [DISP_W*NUM_REQ-1:0]   req_value,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        timeout,
    output logic                        busy,
    output logic                        disp_trigger,
    output logic [DISP_W-1:0]           disp_value,
    input  logic                        disp_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  c_WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t             r_state,   w_state;
    logic [IDX_W-1:0]       r_rr_ptr,  w_rr_ptr;
    logic [IDX_W-1:0]       r_winner,  w_winner;
    logic [WD_W-1:0]        r_wd,      w_wd;
    logic [NUM_REQ-1:0]     r_grant,   w_grant;
    logic [NUM_REQ-1:0]     r_done,    w_done;
    logic                   r_timeout, w_timeout;
    logic                   r_busy,    w_busy;
    logic                   r_trigger, w_trigger;
    logic [DISP_W-1:0]      r_value,   w_value;

    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .winner (w_pick_idx),
        .valid  (w_pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_rr_ptr  <= '0;
            r_winner  <= '0;
            r_wd      <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_trigger <= 1'b0;
            r_value   <= '0;
        end else begin
            r_state   <= w_state;
            r_rr_ptr  <= w_rr_ptr;
            r_winner  <= w_winner;
            r_wd      <= w_wd;
            r_grant   <= w_grant;
            r_done    <= w_done;
            r_timeout <= w_timeout;
            r_busy    <= w_busy;
            r_trigger <= w_trigger;
            r_value   <= w_value;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_rr_ptr  = r_rr_ptr;
        w_winner  = r_winner;
        w_wd      = r_wd;
        w_grant   = r_grant;
        w_done    = r_done;
        w_timeout = r_timeout;
        w_busy    = r_busy;
        w_trigger = r_trigger;
        w_value   = r_value;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_winner             = w_pick_idx;
                    w_grant              = '0;
                    w_grant[w_pick_idx]  = 1'b1;
                    w_value              = req_value[w_pick_idx*DISP_W +: DISP_W];
                    w_trigger            = 1'b1;
                    w_busy               = 1'b1;
                    w_state              = ARB_TRIGGER;
                end
            end

            ARB_TRIGGER: begin
                w_trigger = 1'b0;
                w_wd      = '0;
                w_state   = ARB_WAIT_DONE;
            end

            ARB_WAIT_DONE: begin
                // A completion on the limit cycle is a normal finish, not a timeout.
                if (disp_done) begin
                    w_done           = '0;
                    w_done[r_winner] = 1'b1;
                    w_state          = ARB_RELEASE;
                end else if (r_wd == c_WD_LIMIT) begin
                    w_done           = '0;
                    w_done[r_winner] = 1'b1;
                    w_timeout        = 1'b1;
                    w_state          = ARB_RELEASE;
                end else begin
                    w_wd = r_wd + 1'b1;
                end
            end

            ARB_RELEASE: begin
                w_done    = '0;
                w_timeout = 1'b0;
                w_grant   = '0;
                w_busy    = 1'b0;
                w_rr_ptr  = (r_winner == c_LAST_IDX) ? '0 : r_winner + 1'b1;
                w_state   = ARB_IDLE;
            end

            default: begin
                w_state = ARB_IDLE;
            end
        endcase
    end

    assign grant        = r_grant;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign busy         = r_busy;
    assign disp_trigger = r_trigger;
    assign disp_value   = r_value;

endmodule : display_arbiter
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_arbiter
// Description : Self-checking bench for display_arbiter against a
//               transaction-level round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int N          = 3;
    localparam int TB_TIMEOUT = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_value;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           timeout;
    logic           busy;
    logic           disp_trigger;
    logic [7:0]     disp_value;
    logic           disp_done;

    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;

    display_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_value    (req_value),
        .grant        (grant),
        .done         (done),
        .timeout      (timeout),
        .busy         (busy),
        .disp_trigger (disp_trigger),
        .disp_value   (disp_value),
        .disp_done    (disp_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference rule: first pending request scanning ptr, ptr+1, ... mod N.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        disp_done = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_trigger", disp_trigger, 0);
        check("rst_value", disp_value, 0);
    endtask

    // One full transaction. d = WAIT_DONE cycle index carrying disp_done (<0: never).
    task automatic run_txn(input logic [N-1:0] new_req, input logic [N-1:0] mid_req,
                           input int d, input bit hold);
        int           w;
        logic [7:0]   ev;
        logic [N-1:0] eg;
        bit           fin;
        req       = req | new_req;
        disp_done = 1'b0;
        check("idle_busy", busy, 0);
        w = pick(req, m_ptr);
        if (w < 0) begin
            tick();
            check("idle_no_req", busy, 0);
            return;
        end
        ev    = req_value[w*8 +: 8];
        eg    = '0;
        eg[w] = 1'b1;

        tick();
        check("trig_grant", grant, eg);
        check("trig_value", disp_value, ev);
        check("trig_pulse", disp_trigger, 1);
        check("trig_busy", busy, 1);
        check("trig_done", done, 0);
        req_value = 24'($urandom);
        req       = req | mid_req;
        disp_done = 1'($urandom_range(0, 1));

        tick();
        check("wait_trig_low", disp_trigger, 0);
        check("wait_value", disp_value, ev);
        check("wait_grant", grant, eg);

        fin = 1'b0;
        for (int k = 0; k < TB_TIMEOUT && !fin; k++) begin
            disp_done = (k == d);
            tick();
            disp_done = 1'b0;
            if (k == d || k == TB_TIMEOUT - 1) begin
                fin = 1'b1;
                check("end_done", done, eg);
                check("end_timeout", timeout, (k != d));
                check("end_grant", grant, eg);
                check("end_busy", busy, 1);
            end else begin
                check("wait_done_low", done, 0);
                check("wait_timeout_low", timeout, 0);
            end
        end

        if (!hold) req[w] = 1'b0;
        disp_done = 1'($urandom_range(0, 1));
        tick();
        disp_done = 1'b0;
        check("rel_busy", busy, 0);
        check("rel_grant", grant, 0);
        check("rel_done", done, 0);
        check("rel_timeout", timeout, 0);
        check("rel_trigger", disp_trigger, 0);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_value = '0;
        disp_done = 1'b0;
        do_reset();

        // Single request, disp_done five cycles after the trigger.
        req_value = {8'($urandom), 8'h2A, 8'($urandom)};
        run_txn(3'b010, 3'b000, 4, 1'b0);

        // Simultaneous requests from a fresh pointer, twice around.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            req_value = 24'($urandom);
            run_txn(3'b111, 3'b000, 1, 1'b0);
            run_txn(3'b000, 3'b000, 0, 1'b0);
            run_txn(3'b000, 3'b000, 2, 1'b0);
        end

        // Persistent requester 0; requester 2 arrives mid-transaction.
        run_txn(3'b001, 3'b100, 3, 1'b1);
        run_txn(3'b000, 3'b000, 1, 1'b0);
        run_txn(3'b000, 3'b000, 1, 1'b0);

        // Watchdog abort, then done/timeout tie on the limit cycle.
        run_txn(3'b010, 3'b000, -1, 1'b0);
        run_txn(3'b100, 3'b000, TB_TIMEOUT - 1, 1'b0);

        // Reset mid-transaction with the pointer away from zero.
        run_txn(3'b001, 3'b000, 2, 1'b0);
        req = 3'b010;
        tick();
        tick();
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        rst       = 1'b0;
        disp_done = 1'b1;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        tick();
        disp_done = 1'b0;
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        m_ptr     = 0;
        req_value = 24'($urandom);
        run_txn(3'b101, 3'b000, 0, 1'b0);
        run_txn(3'b000, 3'b000, 1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] nr;
            req_value = 24'($urandom);
            nr        = 3'($urandom_range(0, 7));
            if ((req | nr) == 3'b000) nr = 3'b001 << $urandom_range(0, 2);
            run_txn(nr, 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, TB_TIMEOUT + 1)),
                    ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_display_arbiter
`default_nettype wire

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single seven-segment display controller between NUM_REQ requesters, e.g. round number, final score, countdown digit and attract-mode pattern.
- Each requester presents an 8-bit value plus a request line. The arbiter grants round-robin, latches the value, pulses the controller's trigger and waits for its done.
- It then returns a one-cycle done to the winner.
- A watchdog aborts transactions if the display controller never completes.
- Sits in the game top level between the game state machine / auxiliary sources and sevenseg_display_controller.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- TIMEOUT, 255: cycles in WAIT_DONE before abort (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high; sampled on posedge clk.
- req  in  NUM_REQ  per-requester request; held high until that requester's done.
- req_value  in  8*NUM_REQ  packed values; requester i occupies bits [8i+7:8i].
- grant  out  NUM_REQ  one-hot owner of the display; zero when idle.
- done  out  NUM_REQ  one-cycle pulse to the owner at transaction end.
- timeout  out  1  one-cycle pulse, coincident with done, when the watchdog aborted.
- busy  out  1  high in any state other than IDLE.
- disp_trigger  out  1  one-cycle start pulse to the display controller.
- disp_value  out  8  value for the display controller; stable while busy.
- disp_done  in  1  completion from the display controller.

Behaviour:
- All outputs are registered.
- Reset, at any time including mid-transaction:
  - state=IDLE, rr_ptr=0, grant=0, done=0, timeout=0, busy=0, disp_trigger=0, disp_value=0, watchdog=0.
  - A transaction in flight is dropped; no done is issued for it.
- States: IDLE, TRIGGER, WAIT_DONE, RELEASE (share encoding via the package).
- IDLE:
  - Winner is the first asserted req scanning i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On the edge ending a cycle with any req high:
    - grant <= onehot(winner).
    - disp_value <= req_value[winner].
    - disp_trigger <= 1.
    - busy <= 1.
    - state <= TRIGGER.
  - Latency: req high in cycle t gives grant, disp_value and disp_trigger high in cycle t+1.
- TRIGGER:
  - disp_trigger <= 0, so it is high exactly one cycle.
  - watchdog <= 0.
  - state <= WAIT_DONE.
  - disp_done is ignored in this state.
- WAIT_DONE:
  - If disp_done=1: done[winner] <= 1, state <= RELEASE.
  - Else if watchdog == TIMEOUT-1: done[winner] <= 1, timeout <= 1, state <= RELEASE.
  - Else watchdog += 1 (width clog2(TIMEOUT+1), never wraps).
  - If disp_done arrives in the same cycle the limit is reached, disp_done wins and timeout stays 0.
- RELEASE:
  - done <= 0, timeout <= 0, grant <= 0, busy <= 0.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - state <= IDLE.
  - All req are ignored in this cycle.
- IDLE → IDLE with busy=0 lasts at least one cycle between transactions. Back-to-back throughput is 1 transaction per (disp_done latency + 3) cycles.
- Requester rules:
  - Holds req until it sees done.
  - Must drop req in the cycle after done, or it re-enters arbitration behind the others.
- req or req_value changing while granted has no effect: the value is latched and the sequence completes with done.
- Only one requester is ever granted; done is never issued to a non-granted line.
- A stray disp_done in IDLE, TRIGGER or RELEASE is ignored.

Decomposition:
- Shared package dip_game_pkg holds:
  - state encoding constants: ARB_IDLE, ARB_TRIGGER, ARB_WAIT_DONE, ARB_RELEASE (2-bit).
  - value width constant DISP_W=8.
- One natural sub-module: rr_priority_picker.
  - Inputs: req and rr_ptr.
  - Outputs: winner index and valid.
  - Purely combinational.
  - Reused later by any other shared-resource arbiter.

Test Plan:
- Reset then single request:
  - Stimulus: req=3'b010, value1=0x2A; disp_done 5 cycles after trigger.
  - Response: grant=3'b010, disp_value=0x2A and disp_trigger high one cycle after req. done[1] rises 1 cycle after disp_done. busy falls the cycle after, timeout=0.
- Simultaneous requests:
  - Stimulus: req=3'b111 held continuously; each requester drops req after its done.
  - Response: grant order is 0,1,2. After re-raising all three, the order is again 0,1,2, driven by rr_ptr wrap.
- Fairness with a persistent requester:
  - Stimulus: req0 never drops, req2 raised during req0's transaction.
  - Response: next grant is 2, not 0. Then 0 again.
- Watchdog:
  - Stimulus: TIMEOUT=4, disp_done tied 0.
  - Response: done and timeout pulse together exactly 4 cycles after entering WAIT_DONE. The arbiter returns to IDLE and serves the next request.
- Done vs timeout tie:
  - Stimulus: disp_done asserted in the cycle watchdog==TIMEOUT-1.
  - Response: done=1, timeout=0.
- Reset mid-transaction:
  - Stimulus: rst in WAIT_DONE.
  - Response: the next cycle has grant=0, busy=0 and no done pulse. rr_ptr=0, so with req=3'b101 requester 0 is granted first.
